// File: rtl/sctrl_axi_slave.sv
// sctrl_axi_slave: AXI4 slave front-end for a bank of sensor controllers.
// Per-channel EN/CLEAR/MASK/STATUS registers, read-only data window, masked irq.
module sctrl_axi_slave #(
    parameter int CH_NUM    = 2,
    parameter int DEPTH     = 64,
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [ID_BITS-1:0]            AWID_S,
    input  logic [ADDR_BITS-1:0]          AWADDR_S,
    input  logic [LEN_BITS-1:0]           AWLEN_S,
    input  logic [2:0]                    AWSIZE_S,
    input  logic [1:0]                    AWBURST_S,
    input  logic                          AWVALID_S,
    output logic                          AWREADY_S,
    input  logic [DATA_BITS-1:0]          WDATA_S,
    input  logic [DATA_BITS/8-1:0]        WSTRB_S,
    input  logic                          WLAST_S,
    input  logic                          WVALID_S,
    output logic                          WREADY_S,
    output logic [ID_BITS-1:0]            BID_S,
    output logic [1:0]                    BRESP_S,
    output logic                          BVALID_S,
    input  logic                          BREADY_S,
    input  logic [ID_BITS-1:0]            ARID_S,
    input  logic [ADDR_BITS-1:0]          ARADDR_S,
    input  logic [LEN_BITS-1:0]           ARLEN_S,
    input  logic [2:0]                    ARSIZE_S,
    input  logic [1:0]                    ARBURST_S,
    input  logic                          ARVALID_S,
    output logic                          ARREADY_S,
    output logic [ID_BITS-1:0]            RID_S,
    output logic [DATA_BITS-1:0]          RDATA_S,
    output logic [1:0]                    RRESP_S,
    output logic                          RLAST_S,
    output logic                          RVALID_S,
    input  logic                          RREADY_S,
    output logic [CH_NUM-1:0]             sctrl_en,
    output logic [CH_NUM-1:0]             sctrl_clear,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] sctrl_rd_addr,
    input  logic [CH_NUM*DATA_BITS-1:0]   sctrl_out_all,
    input  logic [CH_NUM-1:0]             sctrl_irq_raw,
    output logic                          sctrl_interrupt
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        K_NONE, K_DATA, K_EN, K_CLR, K_MASK, K_STAT
    } kind_t;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    function automatic kind_t decode(input logic [14:0] a);
        kind_t k;
        k = K_NONE;
        if (32'(a[14:12]) < CH_NUM) begin
            unique case (1'b1)
                (a[11:0] < 12'(DEPTH*4)) && (a[1:0] == 2'b00): k = K_DATA;
                a[11:0] == 12'h100: k = K_EN;
                a[11:0] == 12'h200: k = K_CLR;
                a[11:0] == 12'h300: k = K_MASK;
                a[11:0] == 12'h304: k = K_STAT;
                default:            k = K_NONE;
            endcase
        end
        return k;
    endfunction

    // FIXED keeps the address; every other burst code steps within the 4 KB page.
    function automatic logic [14:0] next_addr(input logic [14:0] a,
                                              input logic [1:0]  burst);
        logic [14:0] n;
        n = a;
        if (burst != 2'b00) n[11:0] = a[11:0] + 12'd4;
        return n;
    endfunction

    rstate_t               rstate;
    wstate_t               wstate;
    logic [ID_BITS-1:0]    rid_q;
    logic [ID_BITS-1:0]    bid_q;
    logic [LEN_BITS-1:0]   rlen_q;
    logic [LEN_BITS-1:0]   rbeat_q;
    logic [1:0]            rburst_q;
    logic [1:0]            wburst_q;
    logic [14:0]           raddr_q;
    logic [14:0]           waddr_q;
    logic [14:0]           raddr_nxt;
    logic [DATA_BITS-1:0]  rdata_q;
    logic [1:0]            rresp_q;
    logic [1:0]            bresp_q;
    logic                  rlast_q;
    logic                  werr_q;
    logic                  irq_q;
    logic [CH_NUM-1:0]     en_q;
    logic [CH_NUM-1:0]     clr_q;
    logic [CH_NUM-1:0]     mask_q;
    logic [IW-1:0]         rd_addr_q;
    kind_t                 r_kind;
    kind_t                 w_kind;
    logic [DATA_BITS-1:0]  r_val;
    logic                  w_err;
    logic                  w_hs;
    logic                  unused_ok;

    assign r_kind    = decode(raddr_q);
    assign w_kind    = decode(waddr_q);
    assign raddr_nxt = next_addr(raddr_q, rburst_q);
    assign w_err     = (w_kind == K_NONE) || (w_kind == K_DATA) ||
                       (w_kind == K_STAT);
    assign w_hs      = (wstate == W_DATA) && WVALID_S;

    always_comb begin
        r_val = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (raddr_q[14:12] == 3'(c)) begin
                case (r_kind)
                    K_DATA:  r_val = sctrl_out_all[c*DATA_BITS +: DATA_BITS];
                    K_EN:    r_val = DATA_BITS'(en_q[c]);
                    K_CLR:   r_val = DATA_BITS'(clr_q[c]);
                    K_MASK:  r_val = DATA_BITS'(mask_q[c]);
                    K_STAT:  r_val = DATA_BITS'(sctrl_irq_raw[c]);
                    default: r_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rstate    <= R_IDLE;
            rid_q     <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rburst_q  <= '0;
            raddr_q   <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ARVALID_S) begin
                        rid_q     <= ARID_S;
                        rlen_q    <= ARLEN_S;
                        rburst_q  <= ARBURST_S;
                        raddr_q   <= ARADDR_S[14:0];
                        rd_addr_q <= ARADDR_S[IW+1:2];
                        rbeat_q   <= '0;
                        rstate    <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q <= r_val;
                    rresp_q <= (r_kind == K_NONE) ? RESP_SLVERR : RESP_OKAY;
                    rlast_q <= (rbeat_q == rlen_q);
                    rstate  <= R_DATA;
                end
                R_DATA: begin
                    if (RREADY_S) begin
                        rlast_q <= 1'b0;
                        if (rlast_q) begin
                            rstate <= R_IDLE;
                        end else begin
                            raddr_q   <= raddr_nxt;
                            rd_addr_q <= raddr_nxt[IW+1:2];
                            rbeat_q   <= rbeat_q + 1'b1;
                            rstate    <= R_FETCH;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wstate   <= W_IDLE;
            bid_q    <= '0;
            wburst_q <= '0;
            waddr_q  <= '0;
            werr_q   <= 1'b0;
            bresp_q  <= RESP_OKAY;
            en_q     <= '0;
            clr_q    <= '0;
            mask_q   <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (AWVALID_S) begin
                        bid_q    <= AWID_S;
                        waddr_q  <= AWADDR_S[14:0];
                        wburst_q <= AWBURST_S;
                        werr_q   <= 1'b0;
                        wstate   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        werr_q  <= werr_q | w_err;
                        waddr_q <= next_addr(waddr_q, wburst_q);
                        if (WLAST_S) begin
                            bresp_q <= (werr_q | w_err) ? RESP_SLVERR : RESP_OKAY;
                            wstate  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY_S) wstate <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
            if (w_hs && !w_err && WSTRB_S[0]) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    if (waddr_q[14:12] == 3'(c)) begin
                        case (w_kind)
                            K_EN:    en_q[c]   <= WDATA_S[0];
                            K_CLR:   clr_q[c]  <= WDATA_S[0];
                            K_MASK:  mask_q[c] <= WDATA_S[0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) irq_q <= 1'b0;
        else          irq_q <= |(sctrl_irq_raw & mask_q);
    end

    // Handshake flags are gated by reset so they drop in the reset cycle itself.
    assign ARREADY_S       = ARESETn && (rstate == R_IDLE);
    assign AWREADY_S       = ARESETn && (wstate == W_IDLE);
    assign WREADY_S        = ARESETn && (wstate == W_DATA);
    assign RVALID_S        = ARESETn && (rstate == R_DATA);
    assign BVALID_S        = ARESETn && (wstate == W_RESP);
    assign RLAST_S         = ARESETn && rlast_q;
    assign RID_S           = rid_q;
    assign RDATA_S         = rdata_q;
    assign RRESP_S         = rresp_q;
    assign BID_S           = bid_q;
    assign BRESP_S         = bresp_q;
    assign sctrl_en        = en_q;
    assign sctrl_clear     = clr_q;
    assign sctrl_rd_addr   = rd_addr_q;
    assign sctrl_interrupt = irq_q;

    assign unused_ok = ^{AWSIZE_S, ARSIZE_S, AWLEN_S,
                         ARADDR_S[ADDR_BITS-1:15], AWADDR_S[ADDR_BITS-1:15],
                         WSTRB_S[DATA_BITS/8-1:1], WDATA_S[DATA_BITS-1:1]};

endmodule

// File: tb/tb_sctrl_axi_slave.sv
// tb_sctrl_axi_slave: directed checks of sctrl_axi_slave (CH_NUM=2, DEPTH=32).
// Channel data source returns 0xA0/0xB0 plus the broadcast word index.
module tb_sctrl_axi_slave;

    logic        ACLK;
    logic        ARESETn;
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic        AWVALID_S;
    logic        AWREADY_S;
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S;
    logic        WVALID_S;
    logic        WREADY_S;
    logic [7:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S;
    logic        BREADY_S;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;
    logic [1:0]  sctrl_en;
    logic [1:0]  sctrl_clear;
    logic [4:0]  sctrl_rd_addr;
    logic [63:0] sctrl_out_all;
    logic [1:0]  sctrl_irq_raw;
    logic        sctrl_interrupt;

    int checks = 0;
    int errors = 0;

    sctrl_axi_slave #(
        .CH_NUM(2), .DEPTH(32), .ID_BITS(8),
        .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
        .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
        .BREADY_S(BREADY_S),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
        .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear),
        .sctrl_rd_addr(sctrl_rd_addr), .sctrl_out_all(sctrl_out_all),
        .sctrl_irq_raw(sctrl_irq_raw), .sctrl_interrupt(sctrl_interrupt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    assign sctrl_out_all = {32'hB0 + 32'(sctrl_rd_addr),
                            32'hA0 + 32'(sctrl_rd_addr)};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input logic [31:0] wdata,
                      input logic [3:0] strb);
        int n;
        AWID_S = 8'h5A; AWADDR_S = addr; AWLEN_S = len;
        AWBURST_S = burst; AWSIZE_S = 3'd2; AWVALID_S = 1'b1;
        n = 0;
        while (!AWREADY_S && n < 20) begin @(negedge ACLK); n++; end
        chk("aw_wait", 32'(n < 20), 1);
        @(negedge ACLK);
        AWVALID_S = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA_S = wdata; WSTRB_S = strb;
            WLAST_S = (i == int'(len)); WVALID_S = 1'b1;
            n = 0;
            while (!WREADY_S && n < 20) begin @(negedge ACLK); n++; end
            chk("w_wait", 32'(n < 20), 1);
            @(negedge ACLK);
        end
        WVALID_S = 1'b0; WLAST_S = 1'b0;
    endtask

    task automatic btake(output logic [1:0] r, output logic [7:0] id);
        int n;
        BREADY_S = 1'b1;
        n = 0;
        while (!BVALID_S && n < 20) begin @(negedge ACLK); n++; end
        chk("b_wait", 32'(n < 20), 1);
        r = BRESP_S; id = BID_S;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic ar(input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] burst);
        int n;
        ARID_S = 8'h33; ARADDR_S = addr; ARLEN_S = len;
        ARBURST_S = burst; ARSIZE_S = 3'd2; ARVALID_S = 1'b1;
        n = 0;
        while (!ARREADY_S && n < 20) begin @(negedge ACLK); n++; end
        chk("ar_wait", 32'(n < 20), 1);
        @(negedge ACLK);
        ARVALID_S = 1'b0;
    endtask

    task automatic wait_rvalid();
        int n;
        n = 0;
        while (!RVALID_S && n < 20) begin @(negedge ACLK); n++; end
        chk("r_wait", 32'(n < 20), 1);
    endtask

    task automatic rbeat(output logic [31:0] d, output logic [1:0] r,
                         output logic l);
        wait_rvalid();
        d = RDATA_S; r = RRESP_S; l = RLAST_S;
        RREADY_S = 1'b1;
        @(negedge ACLK);
        RREADY_S = 1'b0;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [7:0]  id;

    initial begin
        ARESETn = 1'b0;
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0;
        AWBURST_S = '0; AWVALID_S = 1'b0;
        WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0;
        BREADY_S = 1'b0;
        ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0;
        ARBURST_S = '0; ARVALID_S = 1'b0; RREADY_S = 1'b0;
        sctrl_irq_raw = 2'b00;

        repeat (3) @(negedge ACLK);
        chk("rst_arready", 32'(ARREADY_S), 0);
        chk("rst_awready", 32'(AWREADY_S), 0);
        chk("rst_wready", 32'(WREADY_S), 0);
        chk("rst_rvalid", 32'(RVALID_S), 0);
        chk("rst_bvalid", 32'(BVALID_S), 0);
        chk("rst_rlast", 32'(RLAST_S), 0);
        chk("rst_en", 32'(sctrl_en), 0);
        chk("rst_clear", 32'(sctrl_clear), 0);
        chk("rst_rd_addr", 32'(sctrl_rd_addr), 0);
        chk("rst_irq", 32'(sctrl_interrupt), 0);
        chk("rst_rdata", RDATA_S, 0);
        ARESETn = 1'b1;
        #1;
        chk("rel_arready", 32'(ARREADY_S), 1);
        chk("rel_awready", 32'(AWREADY_S), 1);

        // W beat offered with no AW must be refused
        @(negedge ACLK);
        WDATA_S = 32'h1; WSTRB_S = 4'hF; WLAST_S = 1'b1; WVALID_S = 1'b1;
        chk("w_before_aw", 32'(WREADY_S), 0);
        repeat (2) @(negedge ACLK);
        chk("w_before_aw2", 32'(WREADY_S), 0);
        WVALID_S = 1'b0; WLAST_S = 1'b0;
        chk("w_before_aw_en", 32'(sctrl_en), 0);

        wr(32'h0000_1100, 4'd0, 2'b01, 32'h1, 4'hF);
        chk("wr_en_next", 32'(sctrl_en), 32'h2);
        chk("wr_bvalid_next", 32'(BVALID_S), 1);
        btake(r, id);
        chk("wr_bresp", 32'(r), 0);
        chk("wr_bid", 32'(id), 32'h5A);

        ar(32'h0000_1100, 4'd0, 2'b01);
        chk("rd_rvalid_t1", 32'(RVALID_S), 0);
        @(negedge ACLK);
        chk("rd_rvalid_t2", 32'(RVALID_S), 1);
        rbeat(d, r, l);
        chk("rd_en_data", d, 1);
        chk("rd_en_resp", 32'(r), 0);
        chk("rd_en_last", 32'(l), 1);
        chk("rd_rid", 32'(RID_S), 32'h33);

        wr(32'h0000_1100, 4'd0, 2'b01, 32'h0, 4'h0);
        chk("wr_nostrb_en", 32'(sctrl_en), 32'h2);
        btake(r, id);
        chk("wr_nostrb_bresp", 32'(r), 0);

        ar(32'h0000_0000, 4'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            rbeat(d, r, l);
            chk("incr_data", d, 32'hA0 + 32'(i));
            chk("incr_last", 32'(l), 32'(i == 3));
            chk("incr_resp", 32'(r), 0);
        end

        ar(32'h0000_0008, 4'd2, 2'b00);
        wait_rvalid();
        RREADY_S = 1'b0;
        @(negedge ACLK);
        chk("fix_stall_valid", 32'(RVALID_S), 1);
        chk("fix_stall_data", RDATA_S, 32'hA2);
        @(negedge ACLK);
        chk("fix_stall_data2", RDATA_S, 32'hA2);
        chk("fix_stall_last", 32'(RLAST_S), 0);
        for (int i = 0; i < 3; i++) begin
            rbeat(d, r, l);
            chk("fix_data", d, 32'hA2);
            chk("fix_last", 32'(l), 32'(i == 2));
            if (i == 0) begin
                @(negedge ACLK);
                @(negedge ACLK);
            end
        end

        ar(32'h0000_2100, 4'd0, 2'b01);
        rbeat(d, r, l);
        chk("badch_rdata", d, 0);
        chk("badch_rresp", 32'(r), 2);
        ar(32'h0000_0090, 4'd0, 2'b01);
        rbeat(d, r, l);
        chk("gap_rresp", 32'(r), 2);

        wr(32'h0000_00FC, 4'd1, 2'b01, 32'h0, 4'hF);
        btake(r, id);
        chk("gap_burst_bresp", 32'(r), 2);
        chk("gap_burst_en", 32'(sctrl_en), 32'h2);
        wr(32'h0000_2100, 4'd0, 2'b01, 32'h1, 4'hF);
        btake(r, id);
        chk("badch_bresp", 32'(r), 2);
        chk("badch_en", 32'(sctrl_en), 32'h2);
        wr(32'h0000_0004, 4'd0, 2'b01, 32'h1, 4'hF);
        btake(r, id);
        chk("data_wr_bresp", 32'(r), 2);

        wr(32'h0000_0200, 4'd0, 2'b01, 32'h1, 4'hF);
        btake(r, id);
        chk("clear_ch0", 32'(sctrl_clear), 32'h1);

        wr(32'h0000_1300, 4'd0, 2'b01, 32'h1, 4'hF);
        btake(r, id);
        sctrl_irq_raw = 2'b10;
        #1;
        chk("irq_before", 32'(sctrl_interrupt), 0);
        @(negedge ACLK);
        chk("irq_after", 32'(sctrl_interrupt), 1);
        ar(32'h0000_1304, 4'd0, 2'b01);
        rbeat(d, r, l);
        chk("status_ch1", d, 1);
        chk("status_ch1_resp", 32'(r), 0);
        ar(32'h0000_0304, 4'd0, 2'b01);
        rbeat(d, r, l);
        chk("status_ch0", d, 0);
        ar(32'h0000_1300, 4'd0, 2'b01);
        rbeat(d, r, l);
        chk("mask_readback", d, 1);
        wr(32'h0000_1300, 4'd0, 2'b01, 32'h0, 4'hF);
        btake(r, id);
        @(negedge ACLK);
        chk("irq_masked", 32'(sctrl_interrupt), 0);

        ar(32'h0000_0000, 4'd3, 2'b01);
        rbeat(d, r, l);
        chk("midrst_beat0", d, 32'hA0);
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("midrst_rvalid", 32'(RVALID_S), 0);
        chk("midrst_en", 32'(sctrl_en), 0);
        chk("midrst_clear", 32'(sctrl_clear), 0);
        ARESETn = 1'b1;
        repeat (4) @(negedge ACLK);
        chk("midrst_no_r", 32'(RVALID_S), 0);
        chk("midrst_arready", 32'(ARREADY_S), 1);
        chk("midrst_irq", 32'(sctrl_interrupt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sctrl_axi_slave.md
# sctrl_axi_slave

Parametrised AXI4 slave front-end for a bank of `CH_NUM` sensor controllers. It decodes a per-channel register map of control registers and a data window, and supports INCR/FIXED bursts, write strobes, per-channel interrupt masking and SLVERR on undecoded addresses. It sits between the AXI bus (slave port) and the sensor controller instances, and drives the CPU interrupt line.

## Interface
- `CH_NUM`, 2: number of sensor channels, 1..8.
- `DEPTH`, 64: words per channel data window, power of two, 1..64.
- `ID_BITS`, 8: AXI ID width (`AXI_IDS_BITS`).
- `ADDR_BITS`, 32 / `DATA_BITS`, 32 / `LEN_BITS`, 4: AXI address, data and length widths.

- `ACLK` in 1: clock. All logic is on the rising edge.
- `ARESETn` in 1: reset, **synchronous, active-low**.
- AXI AW/W/B/AR/R slave channels (`*_S` suffix), standard AXI4 subset, widths per parameters; `WSTRB_S` is `DATA_BITS/8`.
- `sctrl_en` out `CH_NUM`: per-channel enable register, bit0 of EN.
- `sctrl_clear` out `CH_NUM`: per-channel clear register, bit0 of CLEAR.
- `sctrl_rd_addr` out `$clog2(DEPTH)`: word index, broadcast to all channels.
- `sctrl_out_all` in `CH_NUM*DATA_BITS`: channel c data at `[c*DATA_BITS +: DATA_BITS]`, valid the cycle after `sctrl_rd_addr`.
- `sctrl_irq_raw` in `CH_NUM`: per-channel raw interrupt from the controllers.
- `sctrl_interrupt` out 1: OR over c of `irq_raw[c] & MASK[c]`, registered.

## Operation
- Decode uses `addr[11:0]` for the offset and `addr[14:12]` for the channel. The channel must be < `CH_NUM` and `addr[31:15]` is ignored; an invalid channel gives SLVERR.
- Offset map:
  - 0x000..`DEPTH*4-4`: DATA window, read-only. A write to it gives SLVERR and has no effect.
  - 0x100: EN, RW, bit0.
  - 0x200: CLEAR, RW, bit0.
  - 0x300: MASK, RW, bit0.
  - 0x304: STATUS, read-only, `irq_raw[c]`.
  - Any other offset, including the DATA gap from `DEPTH*4` to 0x0FC: SLVERR. Reads return 0; writes are ignored.
- RW registers update only when `WSTRB_S[0]=1`. Upper bits read as 0.
- Bursts:
  - INCR (01): address += 4 per beat, wrapping within the 4 KB offset.
  - FIXED (00): the same address every beat.
  - WRAP (10) or reserved (11): treated as INCR.
  - `ARSIZE`/`AWSIZE` are ignored; the slave assumes 4-byte beats.
- Read FSM:
  - R_IDLE: `ARREADY_S=1`. On handshake, latch ID, LEN, BURST and address, then go to R_FETCH.
  - R_FETCH: drive `sctrl_rd_addr`, register the decode result. Go to R_DATA.
  - R_DATA: `RVALID_S=1`, holding RDATA, RRESP and RLAST stable until `RREADY_S`. On handshake, go to R_IDLE if this is the last beat, else advance the address and go to R_FETCH.
  - `RLAST_S=1` only on beat `ARLEN`. RRESP is per beat (OKAY or SLVERR). `RID_S` is the latched ARID.
- Write FSM:
  - W_IDLE: `AWREADY_S=1`. On handshake, latch ID, address and BURST, clear the error flag, then go to W_DATA.
  - W_DATA: `WREADY_S=1`. Each W handshake writes the decoded register, ORs any decode error into the error flag and advances the address. On `WLAST_S`, go to W_RESP.
  - W_RESP: `BVALID_S=1` until `BREADY_S`, then go to W_IDLE. `BRESP_S` is SLVERR if the error flag is set, else OKAY. `BID_S` is the latched AWID.
- The read and write FSMs are independent and may run concurrently.
- STATUS read value is `irq_raw` sampled at the R_FETCH edge.

## Timing
- Reset (`ARESETn=0` at an edge):
  - All FSMs go to IDLE.
  - All registers, `sctrl_en`, `sctrl_clear`, `sctrl_rd_addr`, `sctrl_interrupt`, RDATA, RID, BID, RRESP and BRESP are 0.
  - `ARREADY_S`, `AWREADY_S`, `WREADY_S`, `RVALID_S`, `BVALID_S` and `RLAST_S` are 0 while `ARESETn=0`.
  - The READY signals are 1 in the first cycle after release.
- Reset mid-burst: the burst is abandoned and no R or B response is issued.
- Read latency: AR handshake at edge t gives `RVALID_S` high from t+2. One beat per 2 cycles minimum; any `RREADY_S` stall extends that beat.
- Write latency: an EN/CLEAR/MASK write is visible on its output the cycle after the W handshake. `BVALID_S` rises the cycle after the WLAST handshake.
- Same-edge read and write of one register: the read returns the old value if the W handshake and the R_FETCH edge coincide.
- `sctrl_interrupt` follows `irq_raw`/MASK changes with 1 cycle of latency.
- W beats presented before the AW handshake are not accepted (`WREADY_S=0`).

## Test plan
- **Reset:** hold `ARESETn=0` for 3 cycles, then release → all outputs 0 during reset; `ARREADY_S=AWREADY_S=1` on the first cycle after release.
- **Single write:** write 0x1 to 0x1100 with WSTRB=0xF, then read 0x1100 → `sctrl_en=2'b10` the cycle after the W handshake; BRESP=OKAY; RDATA=1 with RLAST=1. Repeat the write with WSTRB=0x0 → `sctrl_en` unchanged.
- **INCR read burst:** read ch0 0x000 with ARLEN=3, with `sctrl_out_all` ch0 = 0xA0+index → RDATA 0xA0, 0xA1, 0xA2, 0xA3; RLAST only on beat 4; RVALID first at t+2.
- **FIXED burst with RREADY stalls:** read 0x0008, ARLEN=2, RREADY toggling → three beats of data 0xA2; values stable while stalled.
- **SLVERR:** with CH_NUM=2, read 0x2100 → RDATA=0, RRESP=SLVERR. Write a 2-beat INCR burst starting at 0x00FC with DEPTH=32 → BRESP=SLVERR; no register changes.
- **Interrupt:** set MASK ch1=1 and drive `irq_raw=2'b10` → `sctrl_interrupt=1` one cycle later. Clear MASK → 0. Read 0x1304 → 1.
